sudoku_game_ctrl: RTL

SUDOKU_GAME_CTRL -- requirements
Module: sudoku_game_ctrl

---
 rtl/sudoku_game_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sudoku_game_ctrl.sv
// sudoku_game_ctrl: top-level game sequencer for a Sudoku board.
//
// Walks the player through difficulty selection, then repeated move entry
// (row, column, value). Each move is handed to an external datapath checker
// (chk_req_o / chk_done_i), and legal moves are committed with wr_en_o.
// Illegal moves cost a life. The game ends in WIN or LOSE, and a key press
// from either end state returns to IDLE for a new game.
//
// Ports
//   clka_i        single clock; all state updates on its rising edge
//   restart_i     asynchronous active-high reset
//   enter_i       user key (level); edge-detected internally
//   din_i         user entry: difficulty, row, column or value by state
//   chk_done_i    one-cycle pulse from the checker: result is valid
//   chk_ok_i      move is legal (qualified by chk_done_i)
//   solved_i      move completes the board (qualified by chk_done_i & chk_ok_i)
//   state_o       current state code
//   row_o/col_o/val_o  latched move fields
//   diff_o        latched difficulty
//   gen_rand_o    high while idle (board generator may free-run)
//   load_board_o  one-cycle pulse when leaving SET_BOARD
//   chk_req_o     high while a move is being checked
//   wr_en_o       one-cycle pulse committing val_o at (row_o, col_o)
//   err_o         one-cycle pulse on an out-of-range entry
//   lives_o       remaining lives
//   moves_o       accepted-move count (saturating)
module sudoku_game_ctrl #(
  parameter int unsigned N     = 9,
  parameter int unsigned W     = 4,
  parameter int unsigned LIVES = 3,
  parameter int unsigned LW    = 2,
  parameter int unsigned MW    = 8
) (
  input  logic          clka_i,
  input  logic          restart_i,
  input  logic          enter_i,
  input  logic [W-1:0]  din_i,
  input  logic          chk_done_i,
  input  logic          chk_ok_i,
  input  logic          solved_i,
  output logic [3:0]    state_o,
  output logic [W-1:0]  row_o,
  output logic [W-1:0]  col_o,
  output logic [W-1:0]  val_o,
  output logic [1:0]    diff_o,
  output logic          gen_rand_o,
  output logic          load_board_o,
  output logic          chk_req_o,
  output logic          wr_en_o,
  output logic          err_o,
  output logic [LW-1:0] lives_o,
  output logic [MW-1:0] moves_o
);

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StSetBoard  = 4'd2,
    StSetDiff   = 4'd3,
    StChooseRow = 4'd4,
    StChooseCol = 4'd5,
    StChooseVal = 4'd6,
    StChecking  = 4'd7,
    StWrong     = 4'd8,
    StWin       = 4'd9,
    StLose      = 4'd10
  } state_e;

  localparam logic [W-1:0]  GridN     = W'(N);
  localparam logic [W-1:0]  DiffMax   = W'(2);
  localparam logic [W-1:0]  ValMin    = W'(1);
  localparam logic [LW-1:0] LivesInit = LW'(LIVES);
  localparam logic [LW-1:0] LivesOne  = LW'(1);
  localparam logic [MW-1:0] MovesMax  = {MW{1'b1}};

  state_e        state_q, state_d;
  logic          enter_q;
  logic [W-1:0]  row_q, row_d;
  logic [W-1:0]  col_q, col_d;
  logic [W-1:0]  val_q, val_d;
  logic [1:0]    diff_q, diff_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [MW-1:0] moves_q, moves_d;
  logic          load_board_q, load_board_d;
  logic          wr_en_q, wr_en_d;
  logic          err_q, err_d;

  // A held key produces a single press: only the rising edge counts.
  logic press;
  assign press = enter_i & ~enter_q;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    val_d        = val_q;
    diff_d       = diff_q;
    lives_d      = lives_q;
    moves_d      = moves_q;
    load_board_d = 1'b0;
    wr_en_d      = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (press) state_d = StSetBoard;
      end

      StSetBoard: begin
        if (press) begin
          state_d      = StSetDiff;
          load_board_d = 1'b1;
        end
      end

      StSetDiff: begin
        if (press) begin
          if (din_i <= DiffMax) begin
            diff_d  = din_i[1:0];
            state_d = StChooseRow;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StChooseRow: begin
        if (press) begin
          if (din_i < GridN) begin
            row_d   = din_i;
            state_d = StChooseCol;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StChooseCol: begin
        if (press) begin
          if (din_i < GridN) begin
            col_d   = din_i;
            state_d = StChooseVal;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StChooseVal: begin
        if (press) begin
          if ((din_i >= ValMin) && (din_i <= GridN)) begin
            val_d   = din_i;
            state_d = StChecking;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // Key presses are ignored here; the checker has no timeout.
      StChecking: begin
        if (chk_done_i) begin
          if (chk_ok_i) begin
            wr_en_d = 1'b1;
            if (moves_q != MovesMax) moves_d = moves_q + MW'(1);
            state_d = solved_i ? StWin : StChooseRow;
          end else if (lives_q <= LivesOne) begin
            lives_d = '0;
            state_d = StLose;
          end else begin
            lives_d = lives_q - LivesOne;
            state_d = StWrong;
          end
        end
      end

      StWrong: begin
        state_d = StChooseRow;
      end

      StWin, StLose: begin
        if (press) begin
          state_d = StIdle;
          lives_d = LivesInit;
          moves_d = '0;
          row_d   = '0;
          col_d   = '0;
          val_d   = '0;
        end
      end

      // Unused codes recover to IDLE.
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clka_i or posedge restart_i) begin
    if (restart_i) begin
      state_q      <= StIdle;
      enter_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      val_q        <= '0;
      diff_q       <= '0;
      lives_q      <= LivesInit;
      moves_q      <= '0;
      load_board_q <= 1'b0;
      wr_en_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      enter_q      <= enter_i;
      row_q        <= row_d;
      col_q        <= col_d;
      val_q        <= val_d;
      diff_q       <= diff_d;
      lives_q      <= lives_d;
      moves_q      <= moves_d;
      load_board_q <= load_board_d;
      wr_en_q      <= wr_en_d;
      err_q        <= err_d;
    end
  end

  assign state_o      = state_q;
  assign row_o        = row_q;
  assign col_o        = col_q;
  assign val_o        = val_q;
  assign diff_o       = diff_q;
  assign lives_o      = lives_q;
  assign moves_o      = moves_q;
  assign load_board_o = load_board_q;
  assign wr_en_o      = wr_en_q;
  assign err_o        = err_q;

  // Decoded straight from the state register so that restart drops them at once.
  assign gen_rand_o = (state_q == StIdle);
  assign chk_req_o  = (state_q == StChecking);

endmodule
